// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Constants shared by the stopwatch display driver and the
//               segment-scan readback monitor: bus widths, the ten active-low
//               7-segment digit patterns ({g,f,e,d,c,b,a} = [6:0]), the blank
//               pattern and the special decoded codes for blank / bad digits.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int AN_W   = 4;   // anode enables, one per digit
    localparam int SEG_W  = 7;   // cathodes a..g
    localparam int DIG_W  = 4;   // BCD digit width

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Decoded codes that fall outside the BCD range
    localparam logic [DIG_W-1:0] DIG_BLANK = 4'hF;
    localparam logic [DIG_W-1:0] DIG_BAD   = 4'hE;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pattern_decode
// Description : Combinational active-low 7-segment pattern to BCD decoder.
//               Ports:
//                 pattern  in  7  cathode pattern, active-low {g..a}
//                 value    out 4  BCD value, DIG_BLANK or DIG_BAD
//                 is_blank out 1  all cathodes off
//                 is_error out 1  pattern is neither a digit nor blank
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0] pattern,
    output logic [DIG_W-1:0] value,
    output logic             is_blank,
    output logic             is_error
);

    always_comb begin
        value    = DIG_BAD;
        is_blank = 1'b0;
        is_error = 1'b0;
        case (pattern)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: begin
                value    = DIG_BLANK;
                is_blank = 1'b1;
            end
            default:   is_error = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_decoder
// Description : Readback monitor for a multiplexed 7-segment bus. Debounces
//               each anode dwell, decodes the cathodes, assembles a 4-digit
//               frame and publishes it with a one-cycle strobe. A watchdog
//               flags a bus on which no digit has been accepted for a while.
//               Ports:
//                 clock_100mhz   in  1   system clock (rising edge)
//                 reset          in  1   asynchronous, active-high
//                 segment_num    in  4   anodes, active-low, bit i = digit i
//                 segment_values in  7   cathodes, active-low {g..a}
//                 digits         out 16  last complete frame, digit i at [4i+3:4i]
//                 blank_mask     out 4   digit i was blank in that frame
//                 frame_error    out 1   some digit in that frame was undecodable
//                 frame_valid    out 1   one-cycle strobe on frame update
//                 stalled        out 1   no accept for TIMEOUT_CYCLES cycles
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clock_100mhz,
    input  logic                  reset,
    input  logic [AN_W-1:0]       segment_num,
    input  logic [SEG_W-1:0]      segment_values,
    output logic [AN_W*DIG_W-1:0] digits,
    output logic [AN_W-1:0]       blank_mask,
    output logic                  frame_error,
    output logic                  frame_valid,
    output logic                  stalled
);

    localparam int                  c_stab_w    = $clog2(STABLE_CYCLES);
    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(STABLE_CYCLES - 2);
    localparam logic [c_stab_w-1:0] c_stab_one  = c_stab_w'(1);
    localparam int                  c_wd_w      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_wd_w-1:0]   c_wd_max    = c_wd_w'(TIMEOUT_CYCLES);
    localparam logic [c_wd_w-1:0]   c_wd_pre    = c_wd_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_wd_w-1:0]   c_wd_one    = c_wd_w'(1);

    logic [AN_W-1:0]       r_samp_num;
    logic [SEG_W-1:0]      r_samp_val;
    logic [c_stab_w-1:0]   r_stab;
    logic                  r_dwell_done;
    logic [AN_W*DIG_W-1:0] r_shadow;
    logic [AN_W-1:0]       r_shadow_blank;
    logic [AN_W-1:0]       r_err;
    logic [AN_W-1:0]       r_seen;
    logic [c_wd_w-1:0]     r_wd;

    logic                  w_in_valid;
    logic                  w_in_same;
    logic                  w_accept;
    logic                  w_complete;
    logic [AN_W-1:0]       w_slot;
    logic [DIG_W-1:0]      w_dec_value;
    logic                  w_dec_blank;
    logic                  w_dec_error;
    logic [AN_W*DIG_W-1:0] w_next_shadow;
    logic [AN_W-1:0]       w_next_blank;
    logic [AN_W-1:0]       w_next_err;

    // The live bus is compared against the registered previous sample, so the
    // STABLE_CYCLES-th identical sample is recognised on the edge it arrives.
    assign w_in_valid = $onehot(~segment_num);
    assign w_in_same  = ({segment_num, segment_values} == {r_samp_num, r_samp_val});
    assign w_accept   = w_in_valid && w_in_same && !r_dwell_done && (r_stab == c_stab_last);

    // On an accept the live and registered samples are identical, so the
    // registered copy is decoded.
    assign w_slot     = ~r_samp_num;
    assign w_complete = w_accept && ((r_seen | w_slot) == {AN_W{1'b1}});

    seg7_pattern_decode u_decode (
        .pattern  (r_samp_val),
        .value    (w_dec_value),
        .is_blank (w_dec_blank),
        .is_error (w_dec_error)
    );

    // Shadow contents including the digit being accepted this cycle.
    always_comb begin
        w_next_shadow = r_shadow;
        w_next_blank  = r_shadow_blank;
        w_next_err    = r_err;
        for (int i = 0; i < AN_W; i++) begin
            if (w_accept && w_slot[i]) begin
                w_next_shadow[i*DIG_W +: DIG_W] = w_dec_value;
                w_next_blank[i]                 = w_dec_blank;
                w_next_err[i]                   = w_dec_error;
            end
        end
    end

    always_ff @(posedge clock_100mhz or posedge reset) begin
        if (reset) begin
            r_samp_num     <= {AN_W{1'b1}};
            r_samp_val     <= SEG_BLANK;
            r_stab         <= '0;
            r_dwell_done   <= 1'b0;
            r_shadow       <= '0;
            r_shadow_blank <= '0;
            r_err          <= '0;
            r_seen         <= '0;
            r_wd           <= '0;
            digits         <= '0;
            blank_mask     <= '0;
            frame_error    <= 1'b0;
            frame_valid    <= 1'b0;
            stalled        <= 1'b0;
        end else begin
            r_samp_num <= segment_num;
            r_samp_val <= segment_values;

            // Debounce: count identical valid samples, fire once per dwell.
            if (!w_in_valid || !w_in_same) begin
                r_stab       <= '0;
                r_dwell_done <= 1'b0;
            end else if (!r_dwell_done) begin
                r_stab       <= r_stab + c_stab_one;
                r_dwell_done <= (r_stab == c_stab_last);
            end

            frame_valid <= w_complete;
            if (w_accept) begin
                r_shadow       <= w_next_shadow;
                r_shadow_blank <= w_next_blank;
                if (w_complete) begin
                    digits      <= w_next_shadow;
                    blank_mask  <= w_next_blank;
                    frame_error <= |w_next_err;
                    r_seen      <= '0;
                    r_err       <= '0;
                end else begin
                    r_seen <= r_seen | w_slot;
                    r_err  <= w_next_err;
                end
            end

            // Watchdog saturates; stalled follows saturation until an accept.
            if (w_accept) begin
                r_wd    <= '0;
                stalled <= 1'b0;
            end else if (r_wd != c_wd_max) begin
                r_wd    <= r_wd + c_wd_one;
                stalled <= (r_wd == c_wd_pre);
            end else begin
                stalled <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_decoder
// Description : Directed self-checking bench for seg_scan_decoder with
//               STABLE_CYCLES=4 and TIMEOUT_CYCLES=64.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    // Active-low patterns written out by hand, {g,f,e,d,c,b,a}
    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P2 = 7'b0100100;
    localparam logic [6:0] P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001;
    localparam logic [6:0] P5 = 7'b0010010;
    localparam logic [6:0] P6 = 7'b0000010;
    localparam logic [6:0] P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000;
    localparam logic [6:0] P9 = 7'b0010000;
    localparam logic [6:0] PB = 7'b1111111;
    localparam logic [6:0] PX = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  segment_num;
    logic [6:0]  segment_values;
    logic [15:0] digits;
    logic [3:0]  blank_mask;
    logic        frame_error;
    logic        frame_valid;
    logic        stalled;

    int   n_checks  = 0;
    int   n_errors  = 0;
    int   n_fv      = 0;
    int   n_consec  = 0;
    int   base;
    logic prev_fv   = 1'b0;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock_100mhz   (clk),
        .reset          (reset),
        .segment_num    (segment_num),
        .segment_values (segment_values),
        .digits         (digits),
        .blank_mask     (blank_mask),
        .frame_error    (frame_error),
        .frame_valid    (frame_valid),
        .stalled        (stalled)
    );

    // Strobe monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (frame_valid) begin
            n_fv++;
            if (prev_fv) n_consec++;
        end
        prev_fv = frame_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] sv, input int n);
        segment_num    = an;
        segment_values = sv;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] d0, input logic [6:0] d1,
                        input logic [6:0] d2, input logic [6:0] d3);
        drive(4'b1110, d0, 5);
        drive(4'b1101, d1, 5);
        drive(4'b1011, d2, 5);
        drive(4'b0111, d3, 5);
    endtask

    initial begin
        reset          = 1'b1;
        segment_num    = 4'b1111;
        segment_values = PB;
        repeat (3) @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h0);
        chk("rst_blank", 32'(blank_mask), 32'h0);
        chk("rst_err", 32'(frame_error), 32'h0);
        chk("rst_fv", 32'(frame_valid), 32'h0);
        chk("rst_stalled", 32'(stalled), 32'h0);
        reset = 1'b0;
        drive(4'b1111, PB, 2);

        // 1: plain scan 5,9,2,1
        base = n_fv;
        scan(P5, P9, P2, P1);
        chk("t1_strobes", 32'(n_fv), 32'(base + 1));
        chk("t1_digits", 32'(digits), 32'h1295);
        chk("t1_blank", 32'(blank_mask), 32'h0);
        chk("t1_err", 32'(frame_error), 32'h0);

        // 2: 3-cycle dwell on digit 2 is ignored
        base = n_fv;
        drive(4'b1011, P7, 3);
        scan(P3, P4, P5, P6);
        chk("t2_strobes", 32'(n_fv), 32'(base + 1));
        chk("t2_digits", 32'(digits), 32'h6543);

        // 3: blank on digit 3, undecodable on digit 1
        base = n_fv;
        scan(P0, PX, P8, PB);
        chk("t3_strobes", 32'(n_fv), 32'(base + 1));
        chk("t3_digits", 32'(digits), 32'hF8E0);
        chk("t3_blank", 32'(blank_mask), 32'h8);
        chk("t3_err", 32'(frame_error), 32'h1);

        // 4: invalid anodes, then watchdog
        chk("t4_not_stalled", 32'(stalled), 32'h0);
        base = n_fv;
        drive(4'b1100, P3, 10);
        drive(4'b1111, P3, 10);
        chk("t4_no_strobe", 32'(n_fv), 32'(base));
        drive(4'b1111, PB, 64);
        chk("t4_stalled", 32'(stalled), 32'h1);
        drive(4'b1110, P4, 3);
        chk("t4_stalled_pre_accept", 32'(stalled), 32'h1);
        @(negedge clk);
        chk("t4_stall_cleared", 32'(stalled), 32'h0);
        @(negedge clk);
        drive(4'b1101, P5, 5);
        drive(4'b1011, P6, 5);
        drive(4'b0111, P7, 5);
        chk("t4_strobes", 32'(n_fv), 32'(base + 1));
        chk("t4_digits", 32'(digits), 32'h7654);
        chk("t4_err", 32'(frame_error), 32'h0);

        // 5: reset mid-frame discards the partial frame
        drive(4'b1110, P1, 5);
        drive(4'b1101, P2, 5);
        reset          = 1'b1;
        segment_num    = 4'b1111;
        segment_values = PB;
        #1;
        chk("t5_rst_digits", 32'(digits), 32'h0);
        chk("t5_rst_blank", 32'(blank_mask), 32'h0);
        repeat (2) @(negedge clk);
        chk("t5_rst_fv", 32'(frame_valid), 32'h0);
        chk("t5_rst_stalled", 32'(stalled), 32'h0);
        reset = 1'b0;
        base  = n_fv;
        drive(4'b1011, P3, 5);
        drive(4'b0111, P4, 5);
        chk("t5_no_early_strobe", 32'(n_fv), 32'(base));
        drive(4'b1110, P5, 5);
        drive(4'b1101, P6, 5);
        chk("t5_strobes", 32'(n_fv), 32'(base + 1));
        chk("t5_digits", 32'(digits), 32'h4365);

        // 6: back-to-back frames, outputs hold until the second strobe
        base = n_fv;
        scan(P9, P8, P7, P6);
        chk("t6_f1_digits", 32'(digits), 32'h6789);
        drive(4'b1110, P1, 5);
        drive(4'b1101, P2, 5);
        drive(4'b1011, P3, 5);
        drive(4'b0111, P4, 3);
        chk("t6_hold_digits", 32'(digits), 32'h6789);
        chk("t6_hold_fv", 32'(frame_valid), 32'h0);
        @(negedge clk);
        chk("t6_f2_digits", 32'(digits), 32'h4321);
        chk("t6_f2_fv", 32'(frame_valid), 32'h1);
        @(negedge clk);
        chk("t6_fv_one_cycle", 32'(frame_valid), 32'h0);
        chk("t6_strobes", 32'(n_fv), 32'(base + 2));
        chk("no_consecutive_fv", 32'(n_consec), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
